// File: rtl/latch_8bit_sync.sv
// Byte-wide holding register that captures din on each rising edge of le.
// The edge is detected against the system clock, so the whole block is synchronous.
module latch_8bit_sync #(
    parameter int                 WIDTH       = 8,
    parameter logic [0:WIDTH-1]   RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               le,
    input  logic [0:WIDTH-1]   din,
    output logic [0:WIDTH-1]   dout,
    output logic               dout_stb
);

    logic               le_q;
    logic               le_d;
    logic [0:WIDTH-1]   dout_q;
    logic [0:WIDTH-1]   dout_d;
    logic               stb_q;
    logic               stb_d;
    logic               le_rise;

    always_comb begin
        le_rise = le & ~le_q;
        le_d    = le;
        dout_d  = dout_q;
        stb_d   = 1'b0;
        if (le_rise) begin
            dout_d = din;
            stb_d  = 1'b1;
        end
    end

    // le_q resets high so an le already asserted at reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= RESET_VALUE;
            stb_q  <= 1'b0;
            le_q   <= 1'b1;
        end else begin
            dout_q <= dout_d;
            stb_q  <= stb_d;
            le_q   <= le_d;
        end
    end

    assign dout     = dout_q;
    assign dout_stb = stb_q;

endmodule

// File: tb/tb_latch_8bit_sync.sv
// Directed bench for latch_8bit_sync: reset, capture, hold, recapture,
// reset/edge interaction and bit ordering.
module tb_latch_8bit_sync;

    logic         clk;
    logic         reset;
    logic         le;
    logic [0:7]   din;
    logic [0:7]   dout;
    logic         dout_stb;

    int checks;
    int errors;

    latch_8bit_sync #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .le       (le),
        .din      (din),
        .dout     (dout),
        .dout_stb (dout_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_dout, input logic exp_stb);
        check({tag, "_dout"}, dout, exp_dout);
        check({tag, "_stb"}, {7'd0, dout_stb}, {7'd0, exp_stb});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        le     = 1'b0;
        din    = 8'hFF;

        // Reset for two clocks with din all ones.
        tick();
        tick();
        check_out("reset", 8'h00, 1'b0);

        // Release reset with le low so le_q is re-armed.
        reset = 1'b0;
        tick();
        check_out("post_reset", 8'h00, 1'b0);

        // Single-clock le pulse captures AA.
        din = 8'hAA;
        le  = 1'b1;
        tick();
        check_out("capture_aa", 8'hAA, 1'b1);
        le = 1'b0;
        tick();
        check_out("after_fall", 8'hAA, 1'b0);

        // din changes with le low are ignored.
        for (int i = 0; i < 10; i++) begin
            din = (i % 2 == 0) ? 8'h00 : 8'h55;
            tick();
            check_out("hold", 8'hAA, 1'b0);
        end

        // New rising edge recaptures; le held high ignores later din.
        din = 8'h00;
        le  = 1'b1;
        tick();
        check_out("recap_00", 8'h00, 1'b1);
        din = 8'h3C;
        tick();
        check_out("held_high1", 8'h00, 1'b0);
        tick();
        check_out("held_high2", 8'h00, 1'b0);
        le = 1'b0;
        tick();
        check_out("rearm", 8'h00, 1'b0);
        le = 1'b1;
        tick();
        check_out("recap_3c", 8'h3C, 1'b1);

        // le held high across reset release: no capture.
        din   = 8'h77;
        reset = 1'b1;
        tick();
        tick();
        check_out("rst_le_high", 8'h00, 1'b0);
        reset = 1'b0;
        tick();
        check_out("release_le_high1", 8'h00, 1'b0);
        tick();
        check_out("release_le_high2", 8'h00, 1'b0);

        // Reset on the same edge as an le rise dominates.
        le = 1'b0;
        tick();
        check_out("arm_before_rst", 8'h00, 1'b0);
        reset = 1'b1;
        le    = 1'b1;
        din   = 8'h99;
        tick();
        check_out("rst_vs_edge", 8'h00, 1'b0);
        reset = 1'b0;
        le    = 1'b0;
        tick();
        check_out("rst_vs_edge_after", 8'h00, 1'b0);

        // Bit ordering: bit 0 is the MSB.
        din = 8'h80;
        le  = 1'b1;
        tick();
        check_out("bitorder", 8'h80, 1'b1);
        check("bit0", {7'd0, dout[0]}, 8'h01);
        check("bits1_7", {1'b0, dout[1:7]}, 8'h00);
        le = 1'b0;
        tick();
        check_out("bitorder_hold", 8'h80, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
